// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. Functions work on the widest legal counter; narrower
// values are zero-extended, which leaves the conversions unchanged.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits do not disturb the result.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin = gray;
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_codec.sv
// Combinational binary<->Gray converter pair; shared with the FIFO pointer synchronisers.
module gray_codec
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out
);

  always_comb begin
    gray_out = WIDTH'(bin2gray(MAX_WIDTH'(bin_in)));
    bin_out  = WIDTH'(gray2bin(MAX_WIDTH'(gray_in)));
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with binary and Gray outputs, binary/Gray load
// and a one-cycle wrap pulse.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RST_VAL)));

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  logic [WIDTH-1:0] unused_load_gray;
  logic [WIDTH-1:0] unused_cur_bin;

  // Load-path conversion: Gray-coded load values become binary.
  gray_codec #(.WIDTH(WIDTH)) u_load_codec (
    .bin_in   (load_val),
    .gray_in  (load_val),
    .gray_out (unused_load_gray),
    .bin_out  (load_bin)
  );

  // Next-state encoding so gray_out is registered alongside bin_out.
  gray_codec #(.WIDTH(WIDTH)) u_next_codec (
    .bin_in   (bin_next),
    .gray_in  (gray_out),
    .gray_out (gray_next),
    .bin_out  (unused_cur_bin)
  );

  // Next-state selection: load beats count; load never reports a wrap.
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up) begin
        bin_next  = bin_out + WIDTH'(1);
        wrap_next = (bin_out == MAX_VAL);
      end else begin
        bin_next  = bin_out - WIDTH'(1);
        wrap_next = (bin_out == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= RST_BIN;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered up/down counter that presents its state in both binary and reflected-binary Gray code every cycle.
- Supports synchronous load from either a binary or a Gray-coded source, and flags wrap-around.
- Serves as the Gray-code source for pointer and position logic (FIFO pointers, encoder positions) where only one output bit may change per step.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- RST_VAL, 0, binary value loaded on reset; must be < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_is_gray  input  1  0 = load_val is binary; 1 = load_val is Gray, converted to binary before loading
- load_val  input  WIDTH  value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out
- wrap  output  1  registered one-cycle pulse: the previous edge wrapped the count (max->0 up, or 0->max down)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: bin_out = RST_VAL; gray_out = RST_VAL ^ (RST_VAL >> 1); wrap = 0.
- Priority per edge is rst > load > en. With none asserted, all outputs hold and wrap = 0.
- Load:
  - bin_out <= load_is_gray ? gray2bin(load_val) : load_val.
  - gray2bin is a prefix XOR: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - wrap <= 0 on load, even if en and the counter is at a boundary.
- Count (en=1, load=0):
  - bin_out <= bin_out + 1 when up=1, bin_out - 1 when up=0, modulo 2**WIDTH.
  - wrap <= 1 only when up=1 and bin_out == 2**WIDTH-1, or up=0 and bin_out == 0.
- gray_out is always registered alongside bin_out: gray_out(next) = bin_next ^ (bin_next >> 1). No combinational path from any input to any output.
- Latency: one cycle from an en, load, or rst edge to updated outputs.
- Gray invariant: across any counting step, including both wraps, exactly one bit of gray_out changes. After a load the Hamming distance is unconstrained.
- Direction change mid-stream (up toggling between consecutive enabled cycles) is legal and takes effect on the same edge.
- rst while load or en is high: reset wins and the load value is discarded.
- wrap is high for exactly one cycle per wrap. Back-to-back wraps (e.g. WIDTH=2, alternating direction at the boundary) pulse on each qualifying edge.
- No X propagation: all state is reset; load_val is sampled only when load=1.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(bin), WIDTH-generic;
  - function gray2bin(gray), WIDTH-generic;
  - localparam MAX_VAL = 2**WIDTH-1 is computed inside the block, not in the package.
- One sub-module is natural: gray_codec, purely combinational, with ports bin_in, gray_in, gray_out, bin_out, parameterised by WIDTH.
  - gray_counter instantiates gray_codec twice: once for load conversion, once for next-state encoding.
  - gray_codec is reusable by the FIFO pointer synchronisers.

Test Plan (WIDTH=4, RST_VAL=0 unless noted):
- Reset: rst=1 for 2 cycles with en=1, load=1 -> bin_out=0000, gray_out=0000, wrap=0.
- Up-count: en=1, up=1 for 16 cycles from 0 -> gray sequence 0000,0001,0011,0010,...,1000,0000; 5 -> 0111; wrap=1 only on the cycle after 15->0; one Gray bit changes per step.
- Down-count wrap: load 0000 binary, then en=1, up=0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle; next cycle bin_out=1110, wrap=0.
- Gray load: load=1, load_is_gray=1, load_val=1011 -> bin_out=1101 (13), gray_out=1011. Binary load 0101 -> gray_out=0111.
- Priority: at bin_out=1111 assert load=1, en=1, up=1, load_val=0011 binary -> bin_out=0011, wrap=0. Same cycle with rst=1 -> bin_out=0000.
- RST_VAL=9, WIDTH=6: reset -> bin_out=001001, gray_out=001101. Full up/down sweep checks the one-bit-change invariant, including both wraps.
